// File: rtl/lcd_host_if.sv
// lcd_host_if
// Host-side partner of the LCD image controller. It plays three roles:
//   * IROM responder : serves the 64-byte 8x8 source image to the controller.
//   * Command issuer : queues host commands and hands them to the controller
//                      one at a time under the busy handshake.
//   * IRAM sink      : captures the processed image the controller writes
//                      back, counts the writes and records completion.
//
// Ports
//   clk, reset              clock (rising edge) / asynchronous active-low reset
//   img_we/img_addr/img_data  host writes into the source-image memory
//   cmd_push/cmd_in         enqueue a command (0 = write-out, else op code)
//   IROM_rd/IROM_A/IROM_Q   controller read port of the source image
//   busy, cmd, cmd_valid    command handshake towards the controller
//   IRAM_valid/IRAM_A/IRAM_D  controller write port into the sink memory
//   done                    controller completion
//   sink_addr/sink_data     host combinational readback of the sink memory
//   wr_count                captured IRAM writes, saturating at 64
//   cmd_full/cmd_empty      command queue status
//   overflow/finished/timeout  sticky status flags
module lcd_host_if #(
  parameter int CMD_DEPTH = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       img_we,
  input  logic [5:0] img_addr,
  input  logic [7:0] img_data,
  input  logic       cmd_push,
  input  logic [3:0] cmd_in,
  input  logic       IROM_rd,
  input  logic [5:0] IROM_A,
  output logic [7:0] IROM_Q,
  input  logic       busy,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  input  logic       IRAM_valid,
  input  logic [5:0] IRAM_A,
  input  logic [7:0] IRAM_D,
  input  logic       done,
  input  logic [5:0] sink_addr,
  output logic [7:0] sink_data,
  output logic [6:0] wr_count,
  output logic       cmd_full,
  output logic       cmd_empty,
  output logic       overflow,
  output logic       finished,
  output logic       timeout
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUED,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Source image memory and IROM read port
  // ---------------------------------------------------------------------------
  logic [7:0] src_mem [64];
  logic [7:0] irom_hold;

  // Memories are deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (img_we) src_mem[img_addr] <= img_data;
  end

  // The combinational path lets the controller sample the pixel on the same
  // edge that advances IROM_A; the hold register keeps the last pixel when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       irom_hold <= '0;
    else if (IROM_rd) irom_hold <= src_mem[IROM_A];
  end

  assign IROM_Q = IROM_rd ? src_mem[IROM_A] : irom_hold;

  // ---------------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------------
  logic [3:0]  fifo_mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          pop, push_ok;

  assign cmd_empty = (count == '0);
  assign cmd_full  = (count == (PW+1)'(CMD_DEPTH));

  // A pop in the same cycle frees a slot, so a push into a full queue still
  // succeeds when the issuer is taking the head.
  assign pop     = (state == S_IDLE) && !cmd_empty && !busy && !finished;
  assign push_ok = cmd_push && (!cmd_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= cmd_in;
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (cmd_push && cmd_full && !pop) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  logic [3:0] cmd_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cmd_reg <= '0;
    end else begin
      state <= state_next;
      if (pop) cmd_reg <= fifo_mem[rd_ptr];
    end
  end

  always_comb begin
    state_next = state;
    cmd_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pop) state_next = S_ISSUED;
      end
      S_ISSUED: begin
        cmd_valid  = 1'b1;
        // A write-out command ends the session: nothing is issued after it.
        state_next = (cmd_reg == 4'd0) ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        // At least one cycle is spent here, so a controller whose busy rises
        // one cycle after acceptance is still seen busy by IDLE.
        if (!busy) state_next = S_IDLE;
      end
      S_DRAIN: begin
        state_next = S_DRAIN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign cmd = cmd_reg;

  // ---------------------------------------------------------------------------
  // IRAM sink
  // ---------------------------------------------------------------------------
  logic [7:0] sink_mem [64];

  always_ff @(posedge clk) begin
    if (IRAM_valid) sink_mem[IRAM_A] <= IRAM_D;
  end

  assign sink_data = sink_mem[sink_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count <= '0;
    end else if (IRAM_valid && (wr_count != 7'd64)) begin
      wr_count <= wr_count + 7'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion and timeout
  // ---------------------------------------------------------------------------
  logic          issued_any;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      finished   <= 1'b0;
      timeout    <= 1'b0;
      issued_any <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      if (done) finished <= 1'b1;
      if (pop) begin
        issued_any <= 1'b1;
        tmo_cnt    <= '0;
      end else if (issued_any && !finished && cmd_empty && !timeout) begin
        // The counter freezes once the flag is raised.
        if (tmo_cnt == TW'(TIMEOUT - 1)) timeout <= 1'b1;
        else                             tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_lcd_host_if.sv
module tb_lcd_host_if;

  logic       clk = 1'b0;
  logic       reset;
  logic       img_we;
  logic [5:0] img_addr;
  logic [7:0] img_data;
  logic       cmd_push;
  logic [3:0] cmd_in;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic [7:0] IROM_Q;
  logic       busy;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       IRAM_valid;
  logic [5:0] IRAM_A;
  logic [7:0] IRAM_D;
  logic       done;
  logic [5:0] sink_addr;
  logic [7:0] sink_data;
  logic [6:0] wr_count;
  logic       cmd_full;
  logic       cmd_empty;
  logic       overflow;
  logic       finished;
  logic       timeout;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];
  int model_cnt;

  always #5 clk = ~clk;

  lcd_host_if #(.CMD_DEPTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
    .cmd_push(cmd_push), .cmd_in(cmd_in),
    .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IROM_Q(IROM_Q),
    .busy(busy), .cmd(cmd), .cmd_valid(cmd_valid),
    .IRAM_valid(IRAM_valid), .IRAM_A(IRAM_A), .IRAM_D(IRAM_D),
    .done(done), .sink_addr(sink_addr), .sink_data(sink_data),
    .wr_count(wr_count), .cmd_full(cmd_full), .cmd_empty(cmd_empty),
    .overflow(overflow), .finished(finished), .timeout(timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_cnt = 0;
  endtask

  task automatic wait_issued(input string tag);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard side: every strobe is one issue, compared with the oldest
  // expected command.
  always @(negedge clk) begin
    if (reset === 1'b1 && cmd_valid === 1'b1) begin
      if (exp_q.size() == 0) check("issue_expected", 32'(exp_q.size() != 0), 1);
      else                   check("issue_cmd", {28'd0, cmd}, {28'd0, exp_q.pop_front()});
      $display("[TB] issue cmd=%0d", cmd);
    end
  end

  initial begin
    reset = 1'b0; img_we = 0; img_addr = 0; img_data = 0; cmd_push = 0; cmd_in = 0;
    IROM_rd = 0; IROM_A = 0; busy = 0; IRAM_valid = 0; IRAM_A = 0; IRAM_D = 0;
    done = 0; sink_addr = 0; model_cnt = 0;
    #2;
    // Reset state
    check("rst_cmd", cmd, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_flags", {overflow, finished, timeout}, 0);
    check("rst_empty", cmd_empty, 1);
    check("rst_full", cmd_full, 0);
    check("rst_irom_q", IROM_Q, 0);
    tick();
    reset = 1'b1;
    tick();

    // Load source image src[i] = i
    for (int i = 0; i < 64; i++) begin
      img_we = 1; img_addr = 6'(i); img_data = 8'(i);
      tick();
    end
    img_we = 0;

    // IROM sweep: combinational read each cycle
    IROM_rd = 1;
    for (int a = 0; a < 64; a++) begin
      IROM_A = 6'(a);
      #1;
      check("irom_read", IROM_Q, a);
      $display("[TB] irom A=%0d Q=%0d", IROM_A, IROM_Q);
      if (a != 63) tick();
    end
    tick();
    IROM_rd = 0; IROM_A = 6'd5;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("irom_hold", IROM_Q, 63);
      tick();
    end

    // Same-cycle write and read of one address returns old data
    img_we = 1; img_addr = 6'd10; img_data = 8'hAA; IROM_rd = 1; IROM_A = 6'd10;
    #1;
    check("irom_rw_old", IROM_Q, 10);
    tick();
    img_we = 0;
    check("irom_rw_new", IROM_Q, 8'hAA);
    IROM_rd = 0;
    tick();

    // Busy hold, queue full and overflow
    busy = 1;
    for (int i = 1; i <= 9; i++) begin
      cmd_push = 1; cmd_in = 4'(i);
      if (model_cnt < 8) begin
        exp_q.push_back(4'(i));
        model_cnt++;
      end
      tick();
      check("valid_while_busy", cmd_valid, 0);
      if (i == 8) begin
        check("full_after_8", cmd_full, 1);
        check("no_overflow_8", overflow, 0);
      end
      $display("[TB] push cmd=%0d full=%0b overflow=%0b", i, cmd_full, overflow);
    end
    cmd_push = 0;
    check("overflow_after_9", overflow, 1);
    check("full_after_9", cmd_full, 1);
    tick();
    tick();
    check("valid_still_busy", cmd_valid, 0);
    busy = 0;
    tick();
    check("release_latency", cmd_valid, 1);
    wait_issued("fifo_order_issued");
    tick();
    check("fifo_empty_after", cmd_empty, 1);
    check("cmd_holds_last", cmd, 8);
    check("overflow_sticky", overflow, 1);

    // 1, 2, 0 sequence: the write-out command ends issuing
    do_reset();
    check("empty_after_reset", cmd_empty, 1);
    foreach (exp_q[k]) exp_q.delete(k);
    for (int i = 0; i < 3; i++) begin
      logic [3:0] seq [3];
      seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd0;
      cmd_push = 1; cmd_in = seq[i];
      exp_q.push_back(seq[i]);
      tick();
    end
    cmd_push = 0;
    wait_issued("seq_issued");
    cmd_push = 1; cmd_in = 4'd5;
    tick();
    cmd_push = 0;
    repeat (10) tick();
    check("drain_no_issue", cmd_empty, 0);

    // IRAM sink capture, completion and saturation
    do_reset();
    for (int a = 0; a < 64; a++) begin
      IRAM_valid = 1; IRAM_A = 6'(a); IRAM_D = 8'(255 - a);
      tick();
      if (a == 31) check("wr_count_mid", wr_count, 32);
    end
    IRAM_valid = 0;
    check("wr_count_64", wr_count, 64);
    check("not_finished_yet", finished, 0);
    done = 1;
    tick();
    done = 0;
    check("finished_set", finished, 1);
    for (int a = 0; a < 64; a++) begin
      sink_addr = 6'(a);
      #1;
      check("sink_data", sink_data, 255 - a);
      $display("[TB] sink A=%0d D=%0d", sink_addr, sink_data);
    end
    IRAM_valid = 1; IRAM_A = 6'd0; IRAM_D = 8'd255;
    tick();
    tick();
    IRAM_valid = 0;
    check("wr_count_sat", wr_count, 64);
    cmd_push = 1; cmd_in = 4'd7;
    tick();
    cmd_push = 0;
    repeat (8) tick();
    check("finished_blocks_issue", cmd_empty, 0);
    check("finished_sticky", finished, 1);

    // Timeout after the last issue
    do_reset();
    cmd_push = 1; cmd_in = 4'd3;
    exp_q.push_back(4'd3);
    tick();
    cmd_push = 0;
    begin
      int k;
      for (k = 0; k < 20 && cmd_valid !== 1'b1; k++) tick();
      check("tmo_issue_seen", cmd_valid, 1);
    end
    repeat (14) tick();
    check("timeout_not_yet", timeout, 0);
    repeat (3) tick();
    check("timeout_set", timeout, 1);
    check("all_issued_tmo", exp_q.size(), 0);

    // Reset mid-operation with a non-empty queue
    busy = 1;
    cmd_push = 1; cmd_in = 4'd4;
    tick();
    cmd_in = 4'd6;
    tick();
    cmd_push = 0;
    check("queue_loaded", cmd_empty, 0);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_flags", {overflow, finished, timeout}, 0);
    check("midrst_empty", cmd_empty, 1);
    check("midrst_full", cmd_full, 0);
    check("midrst_valid", cmd_valid, 0);
    check("midrst_wr_count", wr_count, 0);
    sink_addr = 6'd1;
    IROM_rd = 1; IROM_A = 6'd20;
    #1;
    check("sink_persists", sink_data, 254);
    check("src_persists", IROM_Q, 20);
    IROM_rd = 0;
    busy = 0;
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_host_if.md
Name: lcd_host_if

Overview:
- Host-side counterpart of the LCD controller interface.
- Acts as the IROM responder: it serves the 64-byte 8x8 source image.
- Acts as the command issuer: it drives cmd/cmd_valid under the busy handshake.
- Acts as the IRAM sink: it captures the processed image written back by the controller and flags completion on done.

Parameters:
- CMD_DEPTH, 8, command queue entries; power of two, minimum 2.
- TIMEOUT, 4096, cycles without done after the last command issues before the timeout flag sets.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- img_we  in  1  host write strobe into the source-image memory
- img_addr  in  6  source-image write address
- img_data  in  8  source-image write data
- cmd_push  in  1  enqueue cmd_in into the command queue
- cmd_in  in  4  command to enqueue; 0 = write-out, others = op codes
- IROM_rd  in  1  controller read enable
- IROM_A  in  6  controller read address
- IROM_Q  out  8  source pixel data
- busy  in  1  controller busy
- cmd  out  4  command to controller
- cmd_valid  out  1  command strobe
- IRAM_valid  in  1  controller write strobe
- IRAM_A  in  6  controller write address
- IRAM_D  in  8  controller write data
- done  in  1  controller completion
- sink_addr  in  6  host readback address into the sink memory
- sink_data  out  8  sink memory contents at sink_addr (combinational)
- wr_count  out  7  number of IRAM writes captured, 0..64, saturating
- cmd_full  out  1  queue full
- cmd_empty  out  1  queue empty
- overflow  out  1  sticky: push attempted while full
- finished  out  1  sticky: done observed
- timeout  out  1  sticky: TIMEOUT expired after the last issue

Behaviour:
- Reset (reset=0, asynchronous):
  - cmd=0, cmd_valid=0, wr_count=0, overflow=0, finished=0, timeout=0.
  - Queue emptied: cmd_empty=1, cmd_full=0. Timeout counter cleared.
  - Source and sink memories are not cleared.
  - IROM_Q=0 until the first read.
- IROM responder:
  - When IROM_rd=1, IROM_Q is a combinational read of src[IROM_A], so the controller samples the correct pixel on the same edge that advances IROM_A.
  - When IROM_rd=0, IROM_Q holds the last value read (1 register).
  - An img_we write takes effect at the edge. A same-cycle read of the same address returns the old data.
- Command queue (FIFO):
  - Push when cmd_push=1 and not full.
  - Push while full: data dropped, overflow set.
  - Simultaneous push and pop when full: both succeed.
  - Pointers wrap modulo CMD_DEPTH.
- Issue FSM:
  - IDLE: if !cmd_empty && !busy && !finished, pop the head; cmd<=head, cmd_valid<=1; go to ISSUED.
  - ISSUED (exactly one cycle, cmd_valid=1): cmd_valid<=0; go to WAIT.
    - If the issued cmd==0, go to DRAIN instead.
  - WAIT: return to IDLE on the first cycle busy=0 observed after at least one cycle in WAIT. This covers controllers whose busy rises one cycle after acceptance.
  - DRAIN: terminal until reset. No further issues.
  - cmd holds its last value when cmd_valid=0.
- IRAM sink:
  - Each cycle IRAM_valid=1: sink[IRAM_A]<=IRAM_D and wr_count increments, saturating at 64.
  - Writes are captured in any FSM state.
- Completion:
  - done=1 at an edge sets finished (sticky). Issuing stops.
- Timeout:
  - Counter clears on every issue and counts while !finished && !cmd_empty==0 after at least one issue.
  - On reaching TIMEOUT-1, timeout sets (sticky). The counter then stops.
- Reset mid-operation: all state returns to reset values in the same cycle. Memory contents persist.

Test Plan:
- Load src[i]=i via img_we; drive IROM_rd=1 with IROM_A 0..63 -> IROM_Q equals IROM_A every cycle. Drop rd at A=63 -> IROM_Q stays 63.
- Push cmds 1,2,0 with busy=0 held 1 cycle after each strobe -> three single-cycle cmd_valid pulses carrying 1, 2, 0 in order. No issue after the 0.
- Hold busy=1 with queue non-empty -> cmd_valid stays 0. Release busy -> pulse within 1 cycle.
- Push 9 commands with CMD_DEPTH=8 -> cmd_full=1 after 8, overflow=1 on the 9th. Pops return the first 8 in order.
- Drive IRAM_valid for A=0..63 with D=255-A, then done=1 -> sink_data(A)=255-A, wr_count=64, finished=1. Then 2 extra writes -> wr_count stays 64.
- Issue one command with TIMEOUT=16 and never assert done -> timeout=1 after 16 cycles. Assert reset=0 mid-count -> all flags 0, queue empty.
